mips32_fetch_queue: RTL and testbench



---
 rtl/mips32_pkg.sv | 26 ++
 rtl/mips32_sync_fifo.sv | 91 +++++++++
 rtl/mips32_fetch_queue.sv | 123 ++++++++++++
 tb/tb_mips32_fetch_queue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 fetch front end.
package mips32_pkg;

    localparam logic [5:0] OP_ALU   = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] ir;
    } fetch_entry_t;

    function automatic logic is_hlt(input logic [31:0] ir);
        return ir[31:26] == OP_HLT;
    endfunction

endpackage

// File: rtl/mips32_sync_fifo.sv
// In-order queue of fetch entries with a registered head, synchronous flush
// and an occupancy count used for request credit.
module mips32_sync_fifo
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    fetch_entry_t  head_q, head_d;
    logic          valid_q, valid_d;
    logic          pop_eff;
    logic          push_eff;

    assign pop_eff  = pop_i && valid_q && !flush_i;
    assign push_eff = push_i && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        valid_d  = valid_q;
        if (flush_i) begin
            wr_ptr_d = rd_ptr_q;
            count_d  = '0;
            head_d   = '0;
            valid_d  = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop_eff);
            wr_ptr_d = wr_ptr_q + PW'(push_eff);
            count_d  = count_q + CW'(push_eff) - CW'(pop_eff);
            valid_d  = (count_d != '0);
            // The head register is preloaded so the queue output stays registered;
            // when the queue drains to the incoming word, bypass the array.
            if (!valid_d) begin
                head_d = '0;
            end else if (count_q == CW'(pop_eff)) begin
                head_d = push_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign head_o  = head_q;
    assign count_o = count_q;

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push_eff && !pop_eff && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/mips32_fetch_queue.sv
// Fetch front end: issues word fetches under a queue-space credit, queues
// returned instructions with their next-PC, and squashes on branch redirect.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int                ADDR_W   = 10,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              if_valid,
    output logic [31:0]       if_ir,
    output logic [31:0]       if_npc,
    input  logic              id_ready,
    output logic              halted
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [ADDR_W-1:0] rsp_pc_inc;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_used;
    logic              req_fire;
    logic              rsp_push;
    logic              fifo_pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // Queued entries plus outstanding requests never exceed DEPTH, so every
    // response has a slot waiting for it.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outst_q};
    assign imem_req_valid = rst_n && (state_q == RUN) && !redirect_valid
                            && (credit_used < DEPTH_C);
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_pc_inc = rsp_pc_q + ADDR_W'(1);
    assign rsp_push   = imem_rsp_valid && !redirect_valid && (drop_q == '0);
    assign push_entry = '{npc: 32'(rsp_pc_inc), ir: imem_rsp_data};
    assign fifo_pop   = if_valid && id_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (halt_req) begin
            state_d = HALT;
        end else if (redirect_valid) begin
            state_d = RUN;
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            // Whatever is still in flight once this cycle settles belongs to the old stream.
            drop_d     = outst_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            end
            if (imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    rsp_pc_d = rsp_pc_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    mips32_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (rsp_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .valid_o     (if_valid),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    assign if_ir  = head.ir;
    assign if_npc = head.npc;
    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Randomised bench for mips32_fetch_queue: an in-order memory model plus a
// transaction-level model of the queue contents, checked every cycle.
`timescale 1ns/1ps
module tb_mips32_fetch_queue;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt_req;
    logic              if_valid;
    logic [31:0]       if_ir;
    logic [31:0]       if_npc;
    logic              id_ready;
    logic              halted;

    always #5 clk = ~clk;

    mips32_fetch_queue #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .if_valid       (if_valid),
        .if_ir          (if_ir),
        .if_npc         (if_npc),
        .id_ready       (id_ready),
        .halted         (halted)
    );

    typedef struct { logic [9:0] addr; bit stale; int due; } req_t;
    typedef struct { logic [31:0] npc; logic [31:0] ir; } ent_t;

    req_t        infl[$];      // requests accepted by memory, oldest first
    ent_t        mq[$];        // what ID should see, head first
    logic [9:0]  m_pc;
    bit          m_halted;

    int          cyc, n_tests, n_fail;
    int          lat_min, lat_max, rdy_pct, id_pct, redir_pct, halt_pct;
    bit          force_redirect, force_halt;
    logic [9:0]  force_target;
    int          hs_cnt, first_valid;
    logic [9:0]  hs_addrs[$];
    logic [31:0] got_npc[$];
    bit          watch, watch_hit;
    logic [31:0] watch_npc, watch_ir;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {6'h23, a, 6'h15, ~a};
    endfunction

    function automatic logic [31:0] npc_of(input logic [9:0] a);
        logic [9:0] n;
        n = a + 10'd1;
        return {22'd0, n};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check and advance the model at negedge.
    task automatic step();
        bit   rsp_drv;
        bit   redir;
        bit   exp_req;
        req_t r;
        r = '{addr: '0, stale: 1'b0, due: 0};
        imem_req_ready = int'($urandom_range(99)) < rdy_pct;
        id_ready       = int'($urandom_range(99)) < id_pct;
        redir          = force_redirect || (int'($urandom_range(99)) < redir_pct);
        redirect_valid = redir;
        redirect_pc    = force_redirect ? force_target : 10'($urandom_range(1023));
        halt_req       = force_halt || (int'($urandom_range(99)) < halt_pct);
        rsp_drv        = (infl.size() > 0) && (infl[0].due <= cyc);
        imem_rsp_valid = rsp_drv;
        imem_rsp_data  = rsp_drv ? mem_word(infl[0].addr) : $urandom;
        force_redirect = 1'b0;
        force_halt     = 1'b0;

        @(negedge clk);
        exp_req = !m_halted && !redir && ((mq.size() + infl.size()) < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", 32'(imem_addr), 32'(m_pc));
        chk("if_valid", 32'(if_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("if_npc", if_npc, mq[0].npc);
            chk("if_ir", if_ir, mq[0].ir);
        end
        chk("halted", 32'(halted), 32'(m_halted));

        if (first_valid < 0 && if_valid) first_valid = cyc;
        if (if_valid && id_ready && !redir) begin
            $display("[TB] cyc %0d deliver npc=%h ir=%h", cyc, if_npc, if_ir);
            got_npc.push_back(if_npc);
            if (watch) begin
                watch     = 1'b0;
                watch_hit = 1'b1;
                watch_npc = if_npc;
                watch_ir  = if_ir;
            end
        end

        if (rsp_drv) r = infl.pop_front();
        if (!redir && mq.size() > 0 && id_ready) mq.delete(0);
        if (redir) begin
            mq.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            m_pc = redirect_pc;
        end else if (rsp_drv && !r.stale) begin
            mq.push_back('{npc: npc_of(r.addr), ir: mem_word(r.addr)});
        end
        if (imem_req_valid && imem_req_ready) begin
            hs_cnt++;
            hs_addrs.push_back(imem_addr);
            infl.push_back('{addr: imem_addr, stale: 1'b0,
                             due: cyc + int'($urandom_range(lat_max, lat_min))});
            if (!redir) m_pc = m_pc + 10'd1;
        end
        if (halt_req) m_halted = 1'b1;
        else if (redir) m_halted = 1'b0;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_ir", if_ir, 32'd0);
        chk("rst_if_npc", if_npc, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        infl.delete();
        mq.delete();
        hs_addrs.delete();
        got_npc.delete();
        m_pc        = '0;
        m_halted    = 1'b0;
        cyc         = 0;
        first_valid = -1;
        hs_cnt      = 0;
        watch       = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; id_ready = 1'b0;
        force_redirect = 1'b0; force_halt = 1'b0; force_target = '0;
        watch_hit = 1'b0; watch_npc = '0; watch_ir = '0;
        lat_min = 1; lat_max = 1; rdy_pct = 100; id_pct = 100; redir_pct = 0; halt_pct = 0;
        do_reset();

        // Straight-line fetch with 1-cycle memory
        repeat (8) step();
        chk("first_valid_cycle", 32'(first_valid), 32'd2);
        chk("straight_count", 32'(got_npc.size()), 32'd6);
        if (got_npc.size() >= 6) begin
            chk("straight_npc0", got_npc[0], 32'd1);
            chk("straight_npc5", got_npc[5], 32'd6);
        end

        // Redirect with a same-cycle pop
        force_redirect = 1'b1; force_target = 10'h123; watch = 1'b1; watch_hit = 1'b0;
        repeat (6) step();
        chk("redir_pop_seen", 32'(watch_hit), 32'd1);
        chk("redir_pop_npc", watch_npc, 32'h124);

        // Redirect with a 3-cycle memory in steady state
        lat_min = 3; lat_max = 3;
        repeat (10) step();
        force_redirect = 1'b1; force_target = 10'h200; watch = 1'b1; watch_hit = 1'b0;
        repeat (10) step();
        chk("redir3_seen", 32'(watch_hit), 32'd1);
        chk("redir3_npc", watch_npc, 32'h201);
        chk("redir3_ir", watch_ir, mem_word(10'h200));

        // Halt with requests in flight, then resume by redirect
        lat_min = 2; lat_max = 2;
        repeat (6) step();
        force_halt = 1'b1;
        step();
        hs_cnt = 0;
        repeat (10) step();
        chk("halt_no_issue", 32'(hs_cnt), 32'd0);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_drained", 32'(if_valid), 32'd0);
        force_redirect = 1'b1; force_target = 10'h010; watch = 1'b1; watch_hit = 1'b0;
        repeat (8) step();
        chk("resume_npc", watch_npc, 32'h011);
        chk("resume_halted", 32'(halted), 32'd0);

        // Address wrap
        lat_min = 1; lat_max = 1;
        hs_addrs.delete();
        force_redirect = 1'b1; force_target = 10'h3FF;
        repeat (5) step();
        chk("wrap_hs_count_ok", 32'(hs_addrs.size() >= 2), 32'd1);
        if (hs_addrs.size() >= 2) begin
            chk("wrap_addr0", 32'(hs_addrs[0]), 32'h3FF);
            chk("wrap_addr1", 32'(hs_addrs[1]), 32'h000);
        end

        // Reset mid-stream, then back-pressure from a clean start
        do_reset();
        id_pct = 0;
        repeat (10) step();
        chk("bp_issued", 32'(hs_cnt), 32'd4);
        chk("bp_head_npc", if_npc, 32'd1);
        chk("bp_if_valid", 32'(if_valid), 32'd1);
        chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
        id_pct = 100;
        repeat (10) step();
        chk("bp_release_count", 32'(got_npc.size()), 32'd10);

        // Randomised phases
        for (int ph = 0; ph < 30; ph++) begin
            lat_min   = int'($urandom_range(3, 1));
            lat_max   = lat_min + int'($urandom_range(3));
            rdy_pct   = int'($urandom_range(100, 30));
            id_pct    = int'($urandom_range(100, 20));
            redir_pct = 4;
            halt_pct  = 2;
            if (ph % 10 == 5) do_reset();
            repeat (100) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
